// File: rtl/cpu_datapath.sv
// Datapath for the 8-state RISC CPU: PC, IR, DR, AC, ALU and memory steering; state updates on the clock edge, memory-facing outputs are combinational.
// Latency: zero-cycle mem_*/opcode/zero paths, one edge for register loads. Backpressure: none, the controller strobes are obeyed unconditionally.
module cpu_datapath #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              rd,
    input  logic              ld_ir,
    input  logic              ld_ac,
    input  logic              ld_pc,
    input  logic [1:0]        inc_pc,
    input  logic              wr,
    input  logic              data_e,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_wdata_en,
    output logic [2:0]        opcode,
    output logic              zero,
    output logic [AWIDTH-1:0] pc,
    output logic [DWIDTH-1:0] ac,
    output logic [15:0]       icount
);

    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;

    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] ir_q, ir_d;
    logic [DWIDTH-1:0] dr_q, dr_d;
    logic [DWIDTH-1:0] ac_q, ac_d;
    logic [15:0]       icount_q, icount_d;
    logic [DWIDTH-1:0] alu_res;
    logic [AWIDTH-1:0] ir_operand;
    logic              pc_advance;

    assign ir_operand = ir_q[AWIDTH-1:0];
    assign opcode     = ir_q[DWIDTH-1:AWIDTH];

    assign mem_addr     = sel ? pc_q : ir_operand;
    assign mem_rd       = rd;
    assign mem_wr       = wr;
    assign mem_wdata    = ac_q;
    assign mem_wdata_en = data_e;

    // zero looks at the registered AC so SKZ sees the previous instruction's result.
    assign zero   = (ac_q == '0);
    assign pc     = pc_q;
    assign ac     = ac_q;
    assign icount = icount_q;

    always_comb begin
        alu_res = ac_q;
        case (opcode)
            OP_ADD:  alu_res = ac_q + dr_q;
            OP_AND:  alu_res = ac_q & dr_q;
            OP_XOR:  alu_res = ac_q ^ dr_q;
            OP_LDA:  alu_res = dr_q;
            default: alu_res = ac_q;
        endcase
    end

    always_comb begin
        ir_d = ir_q;
        if (ld_ir) begin
            ir_d = mem_rdata;
        end

        dr_d = dr_q;
        if (rd && !sel) begin
            dr_d = mem_rdata;
        end

        ac_d = ac_q;
        if (ld_ac) begin
            ac_d = alu_res;
        end
    end

    // Jump beats increment; inc_pc code 3 is reserved and holds the PC.
    always_comb begin
        pc_d       = pc_q;
        pc_advance = 1'b0;
        if (ld_pc) begin
            pc_d       = ir_operand;
            pc_advance = 1'b1;
        end else if (inc_pc == 2'd1) begin
            pc_d       = pc_q + AWIDTH'(1);
            pc_advance = 1'b1;
        end else if (inc_pc == 2'd2) begin
            pc_d       = pc_q + AWIDTH'(2);
            pc_advance = 1'b1;
        end

        icount_d = icount_q;
        if (pc_advance) begin
            icount_d = icount_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= '0;
            ir_q     <= '0;
            dr_q     <= '0;
            ac_q     <= '0;
            icount_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            dr_q     <= dr_d;
            ac_q     <= ac_d;
            icount_q <= icount_d;
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: ALU vector table plus hand sequences for fetch, PC wrap, jump and reset.
module tb_cpu_datapath;

    logic       clk;
    logic       rst;
    logic       sel, rd, ld_ir, ld_ac, ld_pc, wr, data_e;
    logic [1:0] inc_pc;
    logic [7:0] mem_rdata;
    logic [4:0] mem_addr;
    logic       mem_rd, mem_wr, mem_wdata_en;
    logic [7:0] mem_wdata;
    logic [2:0] opcode;
    logic       zero;
    logic [4:0] pc;
    logic [7:0] ac;
    logic [15:0] icount;

    logic [7:0] mem [32];
    logic       use_mem;
    logic [7:0] rdata_drv;

    int checks_total;
    int checks_passed;

    assign mem_rdata = use_mem ? mem[mem_addr] : rdata_drv;

    cpu_datapath #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk(clk), .rst(rst), .sel(sel), .rd(rd), .ld_ir(ld_ir), .ld_ac(ld_ac),
        .ld_pc(ld_pc), .inc_pc(inc_pc), .wr(wr), .data_e(data_e),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_wdata_en(mem_wdata_en),
        .opcode(opcode), .zero(zero), .pc(pc), .ac(ac), .icount(icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] ac0;
        logic [7:0] dr;
        logic [7:0] exp_ac;
        logic       exp_z;
    } alu_vec_t;

    alu_vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        sel = 1'b0; rd = 1'b0; ld_ir = 1'b0; ld_ac = 1'b0;
        ld_pc = 1'b0; inc_pc = 2'd0; wr = 1'b0; data_e = 1'b0;
    endtask

    task automatic load_ir(input logic [7:0] v);
        rdata_drv = v; ld_ir = 1'b1;
        tick();
        ld_ir = 1'b0;
    endtask

    task automatic load_dr(input logic [7:0] v);
        rdata_drv = v; rd = 1'b1; sel = 1'b0;
        tick();
        rd = 1'b0;
    endtask

    task automatic pulse_ld_ac();
        ld_ac = 1'b1;
        tick();
        ld_ac = 1'b0;
    endtask

    task automatic load_ac(input logic [7:0] v);
        load_ir(8'hA0);
        load_dr(v);
        pulse_ld_ac();
    endtask

    task automatic set_pc(input logic [4:0] p);
        load_ir({3'd7, p});
        ld_pc = 1'b1;
        tick();
        ld_pc = 1'b0;
    endtask

    initial begin
        logic [15:0] ic0;
        logic [4:0]  pc0;

        checks_total  = 0;
        checks_passed = 0;
        vecs[0] = '{3'd2, 8'hF0, 8'h20, 8'h10, 1'b0};
        vecs[1] = '{3'd2, 8'hE0, 8'h20, 8'h00, 1'b1};
        vecs[2] = '{3'd3, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[3] = '{3'd4, 8'hFF, 8'h0F, 8'hF0, 1'b0};
        vecs[4] = '{3'd4, 8'h3C, 8'h3C, 8'h00, 1'b1};
        vecs[5] = '{3'd5, 8'h12, 8'h55, 8'h55, 1'b0};
        vecs[6] = '{3'd0, 8'h5A, 8'h11, 8'h5A, 1'b0};
        vecs[7] = '{3'd1, 8'h5A, 8'h11, 8'h5A, 1'b0};
        vecs[8] = '{3'd6, 8'h77, 8'h00, 8'h77, 1'b0};
        vecs[9] = '{3'd7, 8'h01, 8'hFF, 8'h01, 1'b0};

        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        use_mem   = 1'b0;
        rdata_drv = 8'h00;
        clear_strobes();
        rst = 1'b0;
        #1;
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_ac", 32'(ac), 32'd0);
        check("reset_opcode", 32'(opcode), 32'd0);
        check("reset_zero", 32'(zero), 32'd1);
        check("reset_icount", 32'(icount), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Full 8-state fetch/execute of LDA 7 from memory.
        mem[0] = 8'hA7;
        mem[7] = 8'h3C;
        use_mem = 1'b1;
        sel = 1'b1;                      tick();
        sel = 1'b1; rd = 1'b1;           tick();
        ld_ir = 1'b1;                    tick();
        check("fetch_opcode", 32'(opcode), 32'd5);
        clear_strobes();                 tick();
        rd = 1'b1;
        #1;
        check("fetch_op_addr", 32'(mem_addr), 32'd7);
        tick();
        check("fetch_ac_before_load", 32'(ac), 32'd0);
        tick();
        rd = 1'b0; ld_ac = 1'b1;         tick();
        check("fetch_ac", 32'(ac), 32'h3C);
        check("fetch_zero", 32'(zero), 32'd0);
        ld_ac = 1'b0; inc_pc = 2'd1;     tick();
        check("fetch_pc", 32'(pc), 32'd1);
        check("fetch_icount", 32'(icount), 32'd1);
        clear_strobes();
        use_mem = 1'b0;

        for (int i = 0; i < 10; i++) begin
            load_ac(vecs[i].ac0);
            load_ir({vecs[i].op, 5'd0});
            load_dr(vecs[i].dr);
            pulse_ld_ac();
            check($sformatf("alu_ac[%0d]", i), 32'(ac), 32'(vecs[i].exp_ac));
            check($sformatf("alu_zero[%0d]", i), 32'(zero), 32'(vecs[i].exp_z));
        end

        set_pc(5'd30);
        inc_pc = 2'd2; tick(); inc_pc = 2'd0;
        check("pc_30_plus2", 32'(pc), 32'd0);
        set_pc(5'd31);
        inc_pc = 2'd2; tick(); inc_pc = 2'd0;
        check("pc_31_plus2", 32'(pc), 32'd1);
        set_pc(5'd31);
        ic0 = icount;
        inc_pc = 2'd1; tick(); inc_pc = 2'd0;
        check("pc_31_plus1", 32'(pc), 32'd0);
        check("icount_inc1", 32'(icount), 32'(ic0 + 16'd1));
        set_pc(5'd9);
        ic0 = icount; pc0 = pc;
        inc_pc = 2'd3; tick(); inc_pc = 2'd0;
        check("pc_reserved", 32'(pc), 32'(pc0));
        check("icount_reserved", 32'(icount), 32'(ic0));
        tick();
        check("pc_halt", 32'(pc), 32'(pc0));
        check("icount_halt", 32'(icount), 32'(ic0));

        load_ir(8'hF9);
        ic0 = icount;
        ld_pc = 1'b1; inc_pc = 2'd1; tick(); clear_strobes();
        check("jmp_pc", 32'(pc), 32'd25);
        check("jmp_icount", 32'(icount), 32'(ic0 + 16'd1));

        // IR and PC load on the same edge: PC takes the old operand.
        load_ir(8'hE3);
        rdata_drv = 8'hEA; ld_ir = 1'b1; ld_pc = 1'b1; tick(); clear_strobes();
        check("ldir_ldpc_pc", 32'(pc), 32'd3);
        #1;
        check("ldir_ldpc_ir", 32'(mem_addr), 32'd10);

        // AC load while DR captures: AC gets the old DR.
        load_ir(8'hA0);
        load_dr(8'h11);
        rdata_drv = 8'h22; rd = 1'b1; sel = 1'b0; ld_ac = 1'b1; tick(); clear_strobes();
        check("ldac_old_dr", 32'(ac), 32'h11);
        pulse_ld_ac();
        check("ldac_new_dr", 32'(ac), 32'h22);

        load_ac(8'h77);
        load_ir(8'hD4);
        sel = 1'b0; wr = 1'b1; data_e = 1'b1;
        #1;
        check("sto_addr", 32'(mem_addr), 32'd20);
        check("sto_wdata", 32'(mem_wdata), 32'h77);
        check("sto_wr", 32'(mem_wr), 32'd1);
        check("sto_wdata_en", 32'(mem_wdata_en), 32'd1);
        check("sto_rd", 32'(mem_rd), 32'd0);
        sel = 1'b1;
        #1;
        check("sel_pc_addr", 32'(mem_addr), 32'(pc));
        clear_strobes();
        tick();

        set_pc(5'd13);
        load_ac(8'h5A);
        check("pre_reset_pc", 32'(pc), 32'd13);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_pc", 32'(pc), 32'd0);
        check("midreset_ac", 32'(ac), 32'd0);
        check("midreset_zero", 32'(zero), 32'd1);
        check("midreset_opcode", 32'(opcode), 32'd0);
        check("midreset_icount", 32'(icount), 32'd0);
        check("midreset_ir_operand", 32'(mem_addr), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Datapath for the 8-state RISC CPU: program counter, instruction register, operand data register, 8-bit accumulator, ALU, zero flag and memory address/data steering. Sits directly downstream of the controller: it consumes the controller's strobes (`sel`, `rd`, `ld_ir`, `ld_ac`, `ld_pc`, `inc_pc`, `wr`, `data_e`) and returns `opcode` and `zero` to it. It drives the single-port instruction/data memory.

## Interface
- `AWIDTH`, 5, address width; also PC width and IR operand field width.
- `DWIDTH`, 8, data/instruction width; must equal 3 + `AWIDTH`.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `sel` in 1: address select; 1 = PC, 0 = IR operand.
- `rd` in 1: memory read strobe from the controller.
- `ld_ir` in 1: load IR from `mem_rdata`.
- `ld_ac` in 1: load AC from the ALU result.
- `ld_pc` in 1: load PC from the IR operand.
- `inc_pc` in 2: PC increment amount.
- `wr` in 1: memory write strobe.
- `data_e` in 1: write-data drive enable.
- `mem_rdata` in `DWIDTH`: memory read data.
- `mem_addr` out `AWIDTH`: memory address.
- `mem_rd` out 1: memory read enable.
- `mem_wr` out 1: memory write enable.
- `mem_wdata` out `DWIDTH`: memory write data, always AC.
- `mem_wdata_en` out 1: write-data valid/drive enable.
- `opcode` out 3: IR[`DWIDTH`-1 : `AWIDTH`].
- `zero` out 1: AC == 0.
- `pc` out `AWIDTH`: current PC (debug).
- `ac` out `DWIDTH`: current AC (debug).
- `icount` out 16: count of retired instructions (debug).

## Operation
- Opcode encoding: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- Reset (`rst`=0, asynchronous): PC, IR, DR, AC and `icount` all go to 0. `opcode` therefore reads HLT and `zero` reads 1.
- `mem_addr` = `sel` ? PC : IR[`AWIDTH`-1:0]. It is combinational.
- `mem_rd` = `rd`, `mem_wr` = `wr`, `mem_wdata_en` = `data_e`. These are combinational pass-through; the block adds no gating.
- IR: on an edge with `ld_ir`=1, IR <= `mem_rdata`.
- DR (operand register): on an edge with `rd`=1 and `sel`=0, DR <= `mem_rdata`. DR holds otherwise.
- ALU, combinational on IR opcode, AC and DR:
  - ADD: (AC+DR) mod 2^`DWIDTH`; carry is dropped.
  - AND: AC&DR.
  - XOR: AC^DR.
  - LDA: DR.
  - All other opcodes: AC unchanged.
- AC: on an edge with `ld_ac`=1, AC <= ALU result.
- `zero` is combinational from the current AC, not from the ALU output.
- PC update, priority order:
  1. `ld_pc`=1: PC <= IR operand.
  2. `inc_pc`=1: PC+1.
  3. `inc_pc`=2: PC+2.
  4. `inc_pc`=0 or 3: hold. Code 3 is reserved and is a no-op.
- PC arithmetic is mod 2^`AWIDTH`: 31+1 gives 0, 30+2 gives 0, 31+2 gives 1.
- `icount` increments by 1 on any edge where `ld_pc`=1 or `inc_pc` is 1 or 2. It wraps at 16 bits. It does not count while halted (`inc_pc`=0).
- Simultaneous `ld_ir` and `ld_pc`: both take effect. PC loads from the old IR operand.
- Simultaneous `ld_ac` and DR capture: AC uses the old DR.

## Timing
- All registers update on the rising `clk`. Reset is asynchronous on assertion; release is sampled on the next rising edge.
- Zero-latency combinational paths:
  - `mem_addr`, `mem_rd`, `mem_wr`, `mem_wdata`, `mem_wdata_en`.
  - `opcode` (from the IR register).
  - `zero` (from the AC register).
- Memory is expected to be combinational-read: `mem_rdata` is valid in the same cycle `mem_addr`/`mem_rd` are presented and is sampled at that cycle's ending edge.
- Per-instruction sequence driven by the controller (cycles 0–7: INST_ADDR, INST_FETCH, INST_LOAD, OP_ADDR, OP_FETCH, ALU_OP, STORE, NEXT):
  - IR loads at the end of cycle 2.
  - DR loads at the end of cycle 4.
  - JMP loads PC at the end of cycle 5.
  - AC loads at the end of cycle 6, because the controller registers `ld_ac` one cycle late.
  - PC increments at the end of cycle 7.
- `zero` therefore reflects the previous instruction's AC during cycle 5 of the current instruction, which SKZ relies on.
- Reset mid-instruction: all registers clear immediately, and the outputs show PC=0, IR=0, AC=0 within the same cycle.

## Test plan
- Reset: assert `rst`=0 with PC=13 and AC=0x5A → PC=0, IR=0, AC=0, `zero`=1 and `opcode`=0 immediately, with no clock edge needed.
- Fetch + LDA: memory[0]=0xA7 (LDA 7), memory[7]=0x3C, drive the 8-state strobe sequence → IR=0xA7 after cycle 2, DR=0x3C after cycle 4, AC=0x3C after cycle 6, PC=1 and `icount`=1 after cycle 7.
- ADD wrap: AC=0xF0, DR=0x20, ADD opcode, pulse `ld_ac` → AC=0x10 and `zero`=0. Then with AC=0xE0, DR=0x20 → AC=0x00 and `zero`=1.
- SKZ and PC wrap:
  - PC=30, `inc_pc`=2 → PC=0.
  - PC=31, `inc_pc`=2 → PC=1.
  - `inc_pc`=3 → PC unchanged and `icount` unchanged.
- JMP: IR=0xF9, `ld_pc`=1 and `inc_pc`=1 on the same edge → PC=25, `icount` +1 only.
- STO: IR=0xD4, AC=0x77, `sel`=0, `wr`=1, `data_e`=1 → `mem_addr`=20, `mem_wdata`=0x77, `mem_wr`=1 and `mem_wdata_en`=1 in the same cycle. Also check `sel`=1 → `mem_addr`=PC.
